aes_round_controller: RTL and testbench

Sequences one AES-128 encryption through the shared combinational round datapath (sub_bytes → shift_rows → mix_columns) and the expanded-key table. It holds the 128-bit round state, selects the round key index, and applies mix_columns on rounds 1..NUM_ROUNDS-1 only, bypassing it on the final round. It sits between the top-level I/O handshake and the round datapath, and it is the only block that drives the mix_columns input.

---
 rtl/aes_round_controller_if.sv | 26 ++
 rtl/aes_round_controller.sv | 110 +++++++++++
 tb/tb_aes_round_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_controller_if.sv
// Handshake and round-datapath signals seen by the AES round controller.
interface aes_round_controller_if;
    logic         i_start;
    logic [127:0] i_data;
    logic [127:0] i_round_key;
    logic [3:0]   o_key_idx;
    logic [127:0] o_dp_data;
    logic [127:0] i_sr_data;
    logic [127:0] o_mc_data;
    logic [127:0] i_mc_data;
    logic         o_busy;
    logic         o_done;
    logic [127:0] o_data;

    // Environment side: top-level I/O, key table and round datapath.
    modport master (
        output i_start, i_data, i_round_key, i_sr_data, i_mc_data,
        input  o_key_idx, o_dp_data, o_mc_data, o_busy, o_done, o_data
    );

    // Controller side.
    modport slave (
        input  i_start, i_data, i_round_key, i_sr_data, i_mc_data,
        output o_key_idx, o_dp_data, o_mc_data, o_busy, o_done, o_data
    );
endinterface

// File: rtl/aes_round_controller.sv
// Sequences one AES-128 encryption through a shared combinational round
// datapath: holds the round state, selects the key index and gates
// mix_columns so the final round bypasses it.
module aes_round_controller #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  n_rst,
    aes_round_controller_if.slave bus
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [DATA_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]  round_q, round_d;
    logic [IDX_W-1:0]  key_idx_q, key_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_round;

    // Final round: result comes straight from shift_rows.
    assign last_round = (round_q >= IDX_W'(NUM_ROUNDS));

    // State and control registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            round_q   <= '0;
            key_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            round_q   <= round_d;
            key_idx_q <= key_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, next round state and registered status outputs.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        key_idx_d = key_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                key_idx_d = '0;
                busy_d    = 1'b0;
                if (bus.i_start) begin
                    state_d   = bus.i_data ^ bus.i_round_key;
                    round_d   = IDX_W'(1);
                    key_idx_d = IDX_W'(1);
                    busy_d    = 1'b1;
                    fsm_d     = ROUND;
                end
            end
            ROUND: begin
                round_d = IDX_W'(round_q + IDX_W'(1));
                if (last_round) begin
                    state_d   = bus.i_sr_data ^ bus.i_round_key;
                    key_idx_d = '0;
                    done_d    = 1'b1;
                    fsm_d     = DONE;
                end else begin
                    state_d   = bus.i_mc_data ^ bus.i_round_key;
                    key_idx_d = IDX_W'(round_q + IDX_W'(1));
                end
            end
            DONE: begin
                round_d   = '0;
                key_idx_d = '0;
                busy_d    = 1'b0;
                fsm_d     = IDLE;
            end
            default: begin
                round_d   = '0;
                key_idx_d = '0;
                busy_d    = 1'b0;
                fsm_d     = IDLE;
            end
        endcase
    end

    // Only rounds 1..NUM_ROUNDS-1 feed mix_columns; otherwise hold it at zero.
    always_comb begin
        bus.o_mc_data = '0;
        if (fsm_q == ROUND && !last_round) begin
            bus.o_mc_data = bus.i_sr_data;
        end
    end

    assign bus.o_key_idx = key_idx_q;
    assign bus.o_dp_data = state_q;
    assign bus.o_data    = state_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_aes_round_controller.sv
// Bench for aes_round_controller: behavioural AES-128 datapath and key
// table around the controller, plus a whole-cipher reference model.
module tb_aes_round_controller;
    localparam int unsigned NR = 10;

    typedef logic [10:0][127:0] ks_t;

    logic clk = 1'b0;
    logic n_rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic [127:0] rk_tab [16];
    logic [127:0] last_ct;

    aes_round_controller_if bus ();

    aes_round_controller #(.NUM_ROUNDS(NR)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = sbox(s[8*(15-i) +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[8*(14-4*c) +: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[8*(13-4*c) +: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[8*(12-4*c) +: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic ks_t expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        ks_t ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Round datapath and key table wrapped around the controller.
    assign bus.i_sr_data   = shift_rows(sub_bytes(bus.o_dp_data));
    assign bus.i_mc_data   = mix_columns(bus.o_mc_data);
    assign bus.i_round_key = rk_tab[bus.o_key_idx];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        ks_t ks;
        ks = expand(key);
        for (int i = 0; i < 16; i++) rk_tab[i] = (i <= 10) ? ks[i] : 128'h0;
    endtask

    // One full encryption, checked every cycle; noisy mode throws start pulses
    // at rounds 3 and NR, in DONE, and randomly elsewhere.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input bit noisy, input bit use_const,
                             input logic [127:0] exp_st0, input logic [127:0] exp_ct);
        ks_t ks;
        logic [127:0] st [NR+1];
        ks = expand(key);
        st[0] = pt ^ ks[0];
        for (int r = 1; r <= NR; r++) begin
            st[r] = shift_rows(sub_bytes(st[r-1]));
            if (r < NR) st[r] = mix_columns(st[r]);
            st[r] = st[r] ^ ks[r];
        end
        @(negedge clk);
        chk("idle_busy", 128'(bus.o_busy), 128'(0));
        chk("idle_done", 128'(bus.o_done), 128'(0));
        chk("idle_key_idx", 128'(bus.o_key_idx), 128'(0));
        chk("idle_mc", bus.o_mc_data, 128'h0);
        load_key(key);
        bus.i_data  = pt;
        bus.i_start = 1'b1;
        for (int cyc = 1; cyc <= NR; cyc++) begin
            @(negedge clk);
            chk("round_busy", 128'(bus.o_busy), 128'(1));
            chk("round_done", 128'(bus.o_done), 128'(0));
            chk("round_key_idx", 128'(bus.o_key_idx), 128'(cyc));
            chk("round_state", bus.o_dp_data, st[cyc-1]);
            chk("round_mc", bus.o_mc_data,
                (cyc < NR) ? shift_rows(sub_bytes(st[cyc-1])) : 128'h0);
            if (use_const && cyc == 1) chk("const_state0", bus.o_dp_data, exp_st0);
            bus.i_data  = {$urandom, $urandom, $urandom, $urandom};
            bus.i_start = noisy ? ((cyc == 3 || cyc == NR) ? 1'b1 : 1'($urandom)) : 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 128'(bus.o_done), 128'(1));
        chk("done_busy", 128'(bus.o_busy), 128'(1));
        chk("done_data", bus.o_data, st[NR]);
        chk("done_mc", bus.o_mc_data, 128'h0);
        if (use_const) chk("const_ct", bus.o_data, exp_ct);
        last_ct = st[NR];
        bus.i_start = noisy;
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        n_rst           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_data      = 128'h0;
        last_ct         = 128'h0;
        for (int i = 0; i < 16; i++) rk_tab[i] = 128'h0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(bus.o_busy), 128'(0));
        chk("rst_done", 128'(bus.o_done), 128'(0));
        chk("rst_data", bus.o_data, 128'h0);
        chk("rst_key_idx", 128'(bus.o_key_idx), 128'(0));
        chk("rst_mc", bus.o_mc_data, 128'h0);
        n_rst = 1'b1;

        // FIPS-197 C.1, then the all-zero vector back-to-back.
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  1'b0, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'h0, 128'h0, 1'b0, 1'b1, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);

        // Ciphertext holds while idle.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            chk("hold_data", bus.o_data, last_ct);
            chk("hold_busy", 128'(bus.o_busy), 128'(0));
            chk("hold_done", 128'(bus.o_done), 128'(0));
        end

        // Start pulses while busy, then random vectors back-to-back.
        for (int b = 0; b < 6; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block(pt, key, (b % 2) == 0, 1'b0, 128'h0, 128'h0);
        end
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("post_noise_busy", 128'(bus.o_busy), 128'(0));

        // Reset in the middle of round 5.
        key = {$urandom, $urandom, $urandom, $urandom};
        load_key(key);
        bus.i_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_key_idx", 128'(bus.o_key_idx), 128'(5));
        n_rst = 1'b0;
        #1;
        chk("midrst_busy", 128'(bus.o_busy), 128'(0));
        chk("midrst_done", 128'(bus.o_done), 128'(0));
        chk("midrst_data", bus.o_data, 128'h0);
        chk("midrst_key_idx", 128'(bus.o_key_idx), 128'(0));
        chk("midrst_mc", bus.o_mc_data, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("postrst_done", 128'(bus.o_done), 128'(0));
            chk("postrst_busy", 128'(bus.o_busy), 128'(0));
            chk("postrst_data", bus.o_data, 128'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
